// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: selects a result source, aligns and extends memory loads,
// and issues a single registered write strobe with done/error status.
module reg_wb_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_start,
  input  logic [1:0]  rf_wr_sel,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] csr_rd,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] mem_dout,
  input  logic        mem_valid,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // Counter only needs to reach TIMEOUT-1 before the last WAIT_MEM cycle is detected.
  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] Poison = 32'hDEADBEEF;

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite, StErr} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [1:0]      r_off;

  logic            w_accept;
  logic            w_misalign;
  logic            w_cnt_last;
  logic [31:0]     w_sel_val;
  logic [31:0]     w_shift;
  logic [31:0]     w_load;
  logic [31:0]     w_data;
  logic [4:0]      w_wa_d;
  logic            w_we_d;
  logic [31:0]     w_wd_d;
  logic            w_busy_d;
  logic            w_done_d;
  logic            w_err_d;

  assign w_accept   = (r_state == StIdle) && wb_start;
  assign w_misalign = (ld_size == 2'd3) ||
                      ((ld_size == 2'd1) && byte_offset[0]) ||
                      ((ld_size == 2'd2) && (byte_offset != 2'd0));
  assign w_cnt_last = (32'(r_cnt) == TIMEOUT - 1);

  always_comb begin
    case (rf_wr_sel)
      2'd0:    w_sel_val = pc_plus4;
      2'd1:    w_sel_val = csr_rd;
      default: w_sel_val = alu_result;
    endcase
  end

  // Legal halves sit at offset 0 or 2, so a plain byte shift covers both field widths.
  always_comb begin
    w_shift = mem_dout >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default: w_load = mem_dout;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (wb_start) begin
          if (rf_wr_sel != 2'd2) begin
            w_state_d = StWrite;
          end else if (w_misalign) begin
            w_state_d = StErr;
          end else begin
            w_state_d = StWaitMem;
          end
        end
      end
      StWaitMem: begin
        if (mem_valid) begin
          w_state_d = StWrite;
        end else if (w_cnt_last) begin
          w_state_d = StErr;
        end
      end
      StWrite: w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the state being entered.
  // A non-memory result is captured straight into rf_wd at acceptance.
  always_comb begin
    w_wa_d   = w_accept ? rd_addr : rf_wa;
    w_data   = (r_state == StIdle) ? w_sel_val : w_load;
    w_we_d   = (w_state_d == StWrite) && (w_wa_d != 5'd0);
    w_wd_d   = w_we_d ? w_data : Poison;
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (w_state_d == StWrite) || (w_state_d == StErr);
    w_err_d  = (w_state_d == StErr);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_we <= 1'b0;
      rf_wa <= 5'd0;
      rf_wd <= Poison;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      rf_we <= w_we_d;
      rf_wa <= w_wa_d;
      rf_wd <= w_wd_d;
      busy  <= w_busy_d;
      done  <= w_done_d;
      error <= w_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_cnt <= '0;
    end else if (r_state == StWaitMem) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_size <= 2'd0;
      r_uns  <= 1'b0;
      r_off  <= 2'd0;
    end else if (w_accept) begin
      r_size <= ld_size;
      r_uns  <= ld_unsigned;
      r_off  <= byte_offset;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: fixed vectors with hand-derived results, random transactions checked
// against a transaction-level model, and reset corner cases.
module tb_reg_wb_ctrl;

  localparam int unsigned TO     = 24;
  localparam int          NEVER  = 1000;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wb_start;
  logic [1:0]  rf_wr_sel;
  logic [31:0] pc_plus4, csr_rd, alu_result;
  logic [4:0]  rd_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [1:0]  byte_offset;
  logic [31:0] mem_dout;
  logic        mem_valid;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] val;
    logic [31:0] mem;
    int          dly;    // mem_valid arrives dly+1 cycles after the wb_start cycle
    logic        e_err;
    logic        e_we;
    logic [31:0] e_wd;
    int          e_k;    // cycle (after the wb_start cycle) in which done is high
  } vec_t;

  vec_t tbl[16];

  reg_wb_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .wb_start(wb_start), .rf_wr_sel(rf_wr_sel),
    .pc_plus4(pc_plus4), .csr_rd(csr_rd), .alu_result(alu_result), .rd_addr(rd_addr),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_offset(byte_offset),
    .mem_dout(mem_dout), .mem_valid(mem_valid), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: outcome and latency straight from the writeback rules.
  function automatic vec_t predict(input vec_t v);
    vec_t        r;
    logic [31:0] mask;
    logic [31:0] fld;
    logic [31:0] val;
    r       = v;
    r.e_err = 1'b0;
    r.e_k   = 1;
    val     = v.val;
    if (v.sel == 2'd2) begin
      if (v.size == 2'd3 || (v.size == 2'd1 && v.off[0]) || (v.size == 2'd2 && v.off != 2'd0)) begin
        r.e_err = 1'b1;
      end else if (v.dly + 1 <= int'(TO)) begin
        r.e_k = v.dly + 2;
        mask  = (v.size == 2'd0) ? 32'hFF : (v.size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        fld   = (v.mem >> (8 * v.off)) & mask;
        if (!v.uns && (fld & ((mask >> 1) + 1)) != 0) fld = fld | ~mask;
        val = fld;
      end else begin
        r.e_k   = 1 + int'(TO);
        r.e_err = 1'b1;
      end
    end
    r.e_we = !r.e_err && (v.rd != 5'd0);
    r.e_wd = r.e_we ? val : POISON;
    return r;
  endfunction

  task automatic scramble();
    wb_start    = 1'($urandom_range(0, 1));
    rf_wr_sel   = 2'($urandom);
    rd_addr     = 5'($urandom);
    ld_size     = 2'($urandom);
    ld_unsigned = 1'($urandom);
    byte_offset = 2'($urandom);
    pc_plus4    = $urandom;
    csr_rd      = $urandom;
    alu_result  = $urandom;
  endtask

  task automatic chk_idle(input logic [4:0] wa);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_error", error, 1'b0);
    chk("idle_rf_we", rf_we, 1'b0);
    chk("idle_rf_wd", rf_wd, POISON);
    chk("idle_rf_wa", rf_wa, wa);
  endtask

  // Entered and left one time unit after a rising edge, in an idle cycle.
  task automatic run_txn(input vec_t v);
    rf_wr_sel   = v.sel;
    rd_addr     = v.rd;
    ld_size     = v.size;
    ld_unsigned = v.uns;
    byte_offset = v.off;
    pc_plus4    = $urandom;
    csr_rd      = $urandom;
    alu_result  = $urandom;
    case (v.sel)
      2'd0:    pc_plus4 = v.val;
      2'd1:    csr_rd = v.val;
      2'd3:    alu_result = v.val;
      default: ;
    endcase
    wb_start  = 1'b1;
    mem_valid = 1'($urandom_range(0, 1));
    mem_dout  = $urandom;
    @(posedge CLK); #1;
    for (int k = 1; k <= v.e_k; k++) begin
      scramble();
      if (k < v.e_k) begin
        mem_valid = (k == v.dly + 1);
        mem_dout  = (k == v.dly + 1) ? v.mem : $urandom;
      end else begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_dout  = $urandom;
      end
      @(negedge CLK);
      chk("busy", busy, 1'b1);
      chk("done", done, k == v.e_k);
      chk("error", error, (k == v.e_k) && v.e_err);
      chk("rf_we", rf_we, (k == v.e_k) && v.e_we);
      chk("rf_wd", rf_wd, (k == v.e_k) ? v.e_wd : POISON);
      chk("rf_wa", rf_wa, v.rd);
      @(posedge CLK); #1;
    end
    wb_start  = 1'b0;
    mem_valid = 1'($urandom_range(0, 1));
    mem_dout  = $urandom;
    @(negedge CLK);
    chk_idle(v.rd);
    @(posedge CLK); #1;
  endtask

  initial begin
    tbl[0]  = '{2'd3, 5'd5,  2'd0, 1'b0, 2'd0, 32'h12345678, 32'h0,        0,     1'b0, 1'b1, 32'h12345678, 1};
    tbl[1]  = '{2'd2, 5'd7,  2'd0, 1'b0, 2'd2, 32'h0,        32'h00800000, 2,     1'b0, 1'b1, 32'hFFFFFF80, 4};
    tbl[2]  = '{2'd2, 5'd9,  2'd1, 1'b1, 2'd2, 32'h0,        32'hBEEF0000, 0,     1'b0, 1'b1, 32'h0000BEEF, 2};
    tbl[3]  = '{2'd2, 5'd3,  2'd2, 1'b0, 2'd1, 32'h0,        32'h0,        0,     1'b1, 1'b0, POISON,       1};
    tbl[4]  = '{2'd2, 5'd4,  2'd2, 1'b0, 2'd0, 32'h0,        32'h0,        NEVER, 1'b1, 1'b0, POISON,       25};
    tbl[5]  = '{2'd3, 5'd0,  2'd0, 1'b0, 2'd0, 32'hA5A5A5A5, 32'h0,        0,     1'b0, 1'b0, POISON,       1};
    tbl[6]  = '{2'd0, 5'd1,  2'd0, 1'b0, 2'd0, 32'h00000104, 32'h0,        0,     1'b0, 1'b1, 32'h00000104, 1};
    tbl[7]  = '{2'd1, 5'd31, 2'd0, 1'b0, 2'd0, 32'hCAFEF00D, 32'h0,        0,     1'b0, 1'b1, 32'hCAFEF00D, 1};
    tbl[8]  = '{2'd2, 5'd10, 2'd1, 1'b0, 2'd0, 32'h0,        32'h12348001, 1,     1'b0, 1'b1, 32'hFFFF8001, 3};
    tbl[9]  = '{2'd2, 5'd11, 2'd0, 1'b1, 2'd3, 32'h0,        32'h80FFFFFF, 0,     1'b0, 1'b1, 32'h00000080, 2};
    tbl[10] = '{2'd2, 5'd12, 2'd2, 1'b0, 2'd0, 32'h0,        32'h89ABCDEF, 23,    1'b0, 1'b1, 32'h89ABCDEF, 25};
    tbl[11] = '{2'd2, 5'd13, 2'd2, 1'b0, 2'd0, 32'h0,        32'h89ABCDEF, 24,    1'b1, 1'b0, POISON,       25};
    tbl[12] = '{2'd2, 5'd14, 2'd3, 1'b0, 2'd0, 32'h0,        32'h0,        0,     1'b1, 1'b0, POISON,       1};
    tbl[13] = '{2'd2, 5'd15, 2'd1, 1'b0, 2'd1, 32'h0,        32'h0,        0,     1'b1, 1'b0, POISON,       1};
    tbl[14] = '{2'd2, 5'd16, 2'd0, 1'b0, 2'd1, 32'h0,        32'hFFFF7FFF, 5,     1'b0, 1'b1, 32'h0000007F, 7};
    tbl[15] = '{2'd2, 5'd0,  2'd2, 1'b0, 2'd0, 32'h0,        32'h11112222, 0,     1'b0, 1'b0, POISON,       2};

    RST = 1'b1;
    wb_start = 1'b0; rf_wr_sel = 2'd0; pc_plus4 = 32'h0; csr_rd = 32'h0; alu_result = 32'h0;
    rd_addr = 5'd0; ld_size = 2'd0; ld_unsigned = 1'b0; byte_offset = 2'd0;
    mem_dout = 32'h0; mem_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    wb_start = 1'b1; rf_wr_sel = 2'd3; rd_addr = 5'd9; mem_valid = 1'b1;
    @(negedge CLK);
    chk_idle(5'd0);
    // Reset outranks a simultaneous wb_start.
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_idle(5'd0);
    RST = 1'b0; wb_start = 1'b0; mem_valid = 1'b0;
    @(posedge CLK); #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int n = 0; n < 200; n++) begin
      vec_t v;
      int   r;
      v.sel  = 2'($urandom);
      v.rd   = 5'($urandom);
      v.size = 2'($urandom_range(0, 3));
      v.uns  = 1'($urandom);
      v.off  = 2'($urandom);
      v.val  = $urandom;
      v.mem  = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      v.dly = NEVER;
      else if (r == 1) v.dly = int'(TO) - 1 + $urandom_range(0, 1);
      else             v.dly = $urandom_range(0, 6);
      run_txn(predict(v));
    end

    // Reset in the middle of a load wait, then a late mem_valid: nothing may be written.
    rf_wr_sel = 2'd2; ld_size = 2'd2; byte_offset = 2'd0; rd_addr = 5'd6; wb_start = 1'b1;
    mem_valid = 1'b0;
    @(posedge CLK); #1;
    wb_start = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("midop_busy", busy, 1'b1);
    chk("midop_rf_wa", rf_wa, 5'd6);
    RST = 1'b1; mem_valid = 1'b1; mem_dout = 32'h55AA55AA; wb_start = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; wb_start = 1'b0;
    @(negedge CLK);
    chk_idle(5'd0);
    @(posedge CLK); #1;
    mem_valid = 1'b0;
    @(negedge CLK);
    chk_idle(5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
